// File: rtl/nand_lane_seq_pkg.sv
// Shared definitions for the NAND lane sequencer: operation codes, FSM
// states and the sizing helper for the pulse-width down-counter.
package nand_lane_seq_pkg;

    localparam logic [2:0] OP_CMD  = 3'd0;
    localparam logic [2:0] OP_ADDR = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_RD   = 3'd3;
    localparam logic [2:0] OP_WAIT = 3'd4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_WE_LO,
        ST_WE_HI,
        ST_RE_LO,
        ST_RE_HI,
        ST_WB_DLY,
        ST_POLL,
        ST_DONE
    } state_t;

    // Counter width: enough bits for the largest timing value plus one spare.
    function automatic int cnt_width(input int t_wp, input int t_wh, input int t_rp,
                                     input int t_reh, input int t_wb, input int timeout);
        int m;
        m = t_wp;
        if (t_wh > m) m = t_wh;
        if (t_rp > m) m = t_rp;
        if (t_reh > m) m = t_reh;
        if (t_wb > m) m = t_wb;
        if (timeout > m) m = timeout;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/nand_lane_seq_sync2.sv
// Two-flop synchronizer for a single asynchronous level (RXB today, IDE
// strobes later). Both flops clear to 0 on reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the asynchronous level through two flops to settle metastability.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/nand_lane_seq.sv
// NAND pin sequencer: takes one primitive operation at a time (CMD, ADDR,
// WR, RD, WAIT), drives the strobe waveforms with programmable widths and
// returns a single-cycle response. Every pin output is a register updated
// together with the state, so a state and its pin levels appear in the same
// cycle.
module nand_lane_seq
    import nand_lane_seq_pkg::*;
#(
    parameter int IO_W    = 8,
    parameter int T_WP    = 2,
    parameter int T_WH    = 2,
    parameter int T_RP    = 2,
    parameter int T_REH   = 2,
    parameter int T_WB    = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [2:0]      REQ_OP,
    input  logic [IO_W-1:0] REQ_DATA,
    input  logic            REQ_LAST,
    output logic            RSP_VALID,
    output logic [IO_W-1:0] RSP_DATA,
    output logic            RSP_ERR,
    output logic [IO_W-1:0] IO_OUT,
    output logic            IO_OE,
    input  logic [IO_W-1:0] IO_IN,
    input  logic            RXB,
    output logic            ALE,
    output logic            CLE,
    output logic            xCE,
    output logic            xRE,
    output logic            xWE
);

    localparam int CNT_W = cnt_width(T_WP, T_WH, T_RP, T_REH, T_WB, TIMEOUT);

    // Reload values: the counter holds "cycles remaining minus one".
    localparam logic [CNT_W-1:0] LD_WP  = CNT_W'(T_WP - 1);
    localparam logic [CNT_W-1:0] LD_WH  = CNT_W'(T_WH - 1);
    localparam logic [CNT_W-1:0] LD_RP  = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] LD_REH = CNT_W'(T_REH - 1);
    localparam logic [CNT_W-1:0] LD_WB  = CNT_W'(T_WB - 1);
    localparam logic [CNT_W-1:0] LD_TO  = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_q;
    logic             rxb_sync;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);

    sync2 u_rxb_sync (
        .clk (CLK),
        .rst (RST),
        .d   (RXB),
        .q   (rxb_sync)
    );

    // Sequencer FSM: state, dwell counter and all registered pin/handshake outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            last_q    <= 1'b0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            RSP_DATA  <= '0;
            IO_OUT    <= '0;
            IO_OE     <= 1'b0;
            ALE       <= 1'b0;
            CLE       <= 1'b0;
            xCE       <= 1'b1;
            xRE       <= 1'b1;
            xWE       <= 1'b1;
        end else begin
            RSP_VALID <= 1'b0;
            RSP_ERR   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (REQ_READY && REQ_VALID) begin
                        REQ_READY <= 1'b0;
                        last_q    <= REQ_LAST;
                        case (REQ_OP)
                            OP_CMD, OP_ADDR, OP_WR: begin
                                state  <= ST_SETUP;
                                xCE    <= 1'b0;
                                IO_OE  <= 1'b1;
                                IO_OUT <= REQ_DATA;
                                CLE    <= (REQ_OP == OP_CMD);
                                ALE    <= (REQ_OP == OP_ADDR);
                            end
                            OP_RD: begin
                                state <= ST_RE_LO;
                                cnt   <= LD_RP;
                                xCE   <= 1'b0;
                                IO_OE <= 1'b0;
                                xRE   <= 1'b0;
                            end
                            OP_WAIT: begin
                                state <= ST_WB_DLY;
                                cnt   <= LD_WB;
                            end
                            default: begin
                                // Illegal op: respond with an error straight away.
                                state     <= ST_DONE;
                                RSP_VALID <= 1'b1;
                                RSP_ERR   <= 1'b1;
                                if (REQ_LAST) xCE <= 1'b1;
                            end
                        endcase
                    end else begin
                        REQ_READY <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state <= ST_WE_LO;
                    cnt   <= LD_WP;
                    xWE   <= 1'b0;
                end
                ST_WE_LO: begin
                    if (cnt_zero) begin
                        state <= ST_WE_HI;
                        cnt   <= LD_WH;
                        xWE   <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WE_HI: begin
                    if (cnt_zero) begin
                        state     <= ST_DONE;
                        RSP_VALID <= 1'b1;
                        CLE       <= 1'b0;
                        ALE       <= 1'b0;
                        IO_OE     <= 1'b0;
                        if (last_q) xCE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RE_LO: begin
                    if (cnt_zero) begin
                        // Sample the bus at the end of the xRE low window.
                        RSP_DATA <= IO_IN;
                        state    <= ST_RE_HI;
                        cnt      <= LD_REH;
                        xRE      <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_RE_HI: begin
                    if (cnt_zero) begin
                        state     <= ST_DONE;
                        RSP_VALID <= 1'b1;
                        if (last_q) xCE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WB_DLY: begin
                    if (cnt_zero) begin
                        state <= ST_POLL;
                        cnt   <= LD_TO;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_POLL: begin
                    if (rxb_sync) begin
                        state     <= ST_DONE;
                        RSP_VALID <= 1'b1;
                        if (last_q) xCE <= 1'b1;
                    end else if (cnt_zero) begin
                        state     <= ST_DONE;
                        RSP_VALID <= 1'b1;
                        RSP_ERR   <= 1'b1;
                        if (last_q) xCE <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    REQ_READY <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nand_lane_seq.sv
// Bench for nand_lane_seq: a directed table of operations with hand-computed
// expectations, a reset-during-write sequence, and a randomized run checked
// against a per-operation behavioural model.
module tb_nand_lane_seq;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [2:0] REQ_OP = 3'd0;
    logic [7:0] REQ_DATA = 8'd0;
    logic       REQ_LAST = 1'b0;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       RSP_ERR;
    logic [7:0] IO_OUT;
    logic       IO_OE;
    logic [7:0] IO_IN = 8'd0;
    logic       RXB = 1'b0;
    logic       ALE, CLE, xCE, xRE, xWE;

    nand_lane_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_OP    (REQ_OP),
        .REQ_DATA  (REQ_DATA),
        .REQ_LAST  (REQ_LAST),
        .RSP_VALID (RSP_VALID),
        .RSP_DATA  (RSP_DATA),
        .RSP_ERR   (RSP_ERR),
        .IO_OUT    (IO_OUT),
        .IO_OE     (IO_OE),
        .IO_IN     (IO_IN),
        .RXB       (RXB),
        .ALE       (ALE),
        .CLE       (CLE),
        .xCE       (xCE),
        .xRE       (xRE),
        .xWE       (xWE)
    );

    always #5 CLK = ~CLK;

    localparam int P_WP = 2, P_WH = 2, P_RP = 2, P_REH = 2, P_WB = 4, P_TO = 1000;

    int total = 0;
    int bad   = 0;

    // Observed results of the last operation.
    int r_lat, r_err, r_rdata, r_ce, r_we, r_cle, r_ale, r_oe, r_re, r_io_bad, r_wait, r_idle_ok;
    // Model state and expectations.
    int m_ce = 1, m_rdata = 0;
    int e_lat, e_err, e_ce, e_we, e_cle, e_ale, e_oe, e_re;

    typedef struct {
        logic [2:0] op;
        logic [7:0] data;
        logic       last;
        logic [7:0] io_in;
        int         rise;
        int         lat;
        int         err;
        int         rdata;
        int         ce;
        int         we;
        int         cle;
        int         ale;
        int         oe;
        int         re;
    } vec_t;

    vec_t tbl [11];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Issue one operation and record the pin activity until its response.
    task automatic run_op(input logic [2:0] op, input logic [7:0] data, input logic last,
                          input logic [7:0] io_v, input int rise);
        r_wait = 0;
        do begin
            @(negedge CLK);
            r_wait++;
        end while (!REQ_READY && r_wait < 50);
        r_idle_ok = (CLE == 1'b0 && ALE == 1'b0 && xWE == 1'b1 && xRE == 1'b1 && REQ_READY == 1'b1) ? 1 : 0;
        RXB       = 1'b0;
        IO_IN     = io_v;
        REQ_OP    = op;
        REQ_DATA  = data;
        REQ_LAST  = last;
        REQ_VALID = 1'b1;
        @(posedge CLK);
        #1;
        REQ_VALID = 1'b0;
        REQ_OP    = 3'($urandom);
        REQ_DATA  = 8'($urandom);
        REQ_LAST  = 1'($urandom);
        r_lat = -1; r_err = -1; r_rdata = -1; r_ce = -1;
        r_we = 0; r_cle = 0; r_ale = 0; r_oe = 0; r_re = 0; r_io_bad = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge CLK);
            if (!xWE) r_we++;
            if (!xRE) r_re++;
            if (CLE) r_cle++;
            if (ALE) r_ale++;
            if (IO_OE) r_oe++;
            if (IO_OE && IO_OUT != data) r_io_bad++;
            if (RSP_VALID) begin
                r_lat   = k;
                r_err   = int'(RSP_ERR);
                r_rdata = int'(RSP_DATA);
                r_ce    = int'(xCE);
                break;
            end
            if (rise != 0 && k == rise) RXB = 1'b1;
        end
    endtask

    task automatic check_op(input string tag, input int lat, input int err, input int rdata,
                            input int ce, input int we, input int cle, input int ale,
                            input int oe, input int re, input bit gap);
        chk({tag, ".lat"}, r_lat, lat);
        chk({tag, ".err"}, r_err, err);
        chk({tag, ".rdata"}, r_rdata, rdata);
        chk({tag, ".xce"}, r_ce, ce);
        chk({tag, ".xwe_lo"}, r_we, we);
        chk({tag, ".cle"}, r_cle, cle);
        chk({tag, ".ale"}, r_ale, ale);
        chk({tag, ".io_oe"}, r_oe, oe);
        chk({tag, ".xre_lo"}, r_re, re);
        chk({tag, ".io_out"}, r_io_bad, 0);
        if (gap) begin
            chk({tag, ".gap"}, r_wait, 1);
            chk({tag, ".idle"}, r_idle_ok, 1);
        end
    endtask

    // Reference: expected response from the operation rules alone.
    task automatic model(input logic [2:0] op, input logic last, input logic [7:0] io_v, input int rise);
        int poll_start, seen;
        e_err = 0; e_we = 0; e_cle = 0; e_ale = 0; e_oe = 0; e_re = 0;
        if (op <= 3'd2) begin
            e_lat = 1 + P_WP + P_WH + 1;
            e_we  = P_WP;
            e_oe  = 1 + P_WP + P_WH;
            e_cle = (op == 3'd0) ? e_oe : 0;
            e_ale = (op == 3'd1) ? e_oe : 0;
            m_ce  = last ? 1 : 0;
        end else if (op == 3'd3) begin
            e_lat   = P_RP + P_REH + 1;
            e_re    = P_RP;
            m_rdata = int'(io_v);
            m_ce    = last ? 1 : 0;
        end else if (op == 3'd4) begin
            poll_start = P_WB + 1;
            seen = rise + 2;
            if (rise == 0 || seen > P_WB + P_TO) begin
                e_lat = P_WB + P_TO + 1;
                e_err = 1;
            end else begin
                e_lat = ((seen > poll_start) ? seen : poll_start) + 1;
            end
            if (last) m_ce = 1;
        end else begin
            e_lat = 1;
            e_err = 1;
            if (last) m_ce = 1;
        end
        e_ce = m_ce;
    endtask

    int rv_seen;

    initial begin
        // CMD FF, ADDR 12, WR A5 back-to-back, RD 3C, WAIT with ready/timeout, illegal ops.
        tbl[0]  = '{3'd0, 8'hFF, 1'b0, 8'h00, 0,    6,    0, 'h00, 0, 2, 5, 0, 5, 0};
        tbl[1]  = '{3'd1, 8'h12, 1'b0, 8'h00, 0,    6,    0, 'h00, 0, 2, 0, 5, 5, 0};
        tbl[2]  = '{3'd2, 8'hA5, 1'b0, 8'h00, 0,    6,    0, 'h00, 0, 2, 0, 0, 5, 0};
        tbl[3]  = '{3'd3, 8'h00, 1'b0, 8'h3C, 0,    5,    0, 'h3C, 0, 0, 0, 0, 0, 2};
        tbl[4]  = '{3'd4, 8'h00, 1'b1, 8'h00, 20,   23,   0, 'h3C, 1, 0, 0, 0, 0, 0};
        tbl[5]  = '{3'd6, 8'h00, 1'b0, 8'h00, 0,    1,    1, 'h3C, 1, 0, 0, 0, 0, 0};
        tbl[6]  = '{3'd0, 8'h70, 1'b0, 8'h00, 0,    6,    0, 'h3C, 0, 2, 5, 0, 5, 0};
        tbl[7]  = '{3'd4, 8'h00, 1'b0, 8'h00, 0,    1005, 1, 'h3C, 0, 0, 0, 0, 0, 0};
        tbl[8]  = '{3'd7, 8'h00, 1'b1, 8'h00, 0,    1,    1, 'h3C, 1, 0, 0, 0, 0, 0};
        tbl[9]  = '{3'd4, 8'h00, 1'b0, 8'h00, 3,    6,    0, 'h3C, 1, 0, 0, 0, 0, 0};
        tbl[10] = '{3'd3, 8'h00, 1'b1, 8'hC3, 0,    5,    0, 'hC3, 1, 0, 0, 0, 0, 2};

        // Reset values while RST is held.
        repeat (3) @(negedge CLK);
        chk("rst.xce", int'(xCE), 1);
        chk("rst.xre", int'(xRE), 1);
        chk("rst.xwe", int'(xWE), 1);
        chk("rst.ale", int'(ALE), 0);
        chk("rst.cle", int'(CLE), 0);
        chk("rst.io_oe", int'(IO_OE), 0);
        chk("rst.req_ready", int'(REQ_READY), 0);
        chk("rst.rsp_valid", int'(RSP_VALID), 0);
        chk("rst.rsp_err", int'(RSP_ERR), 0);
        chk("rst.io_out", int'(IO_OUT), 0);
        chk("rst.rsp_data", int'(RSP_DATA), 0);
        RST = 1'b0;
        #1;
        chk("rel.req_ready_low", int'(REQ_READY), 0);
        @(negedge CLK);
        chk("rel.req_ready_high", int'(REQ_READY), 1);

        // Directed table.
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].data, tbl[i].last, tbl[i].io_in, tbl[i].rise);
            check_op($sformatf("tbl%0d", i), tbl[i].lat, tbl[i].err, tbl[i].rdata, tbl[i].ce,
                     tbl[i].we, tbl[i].cle, tbl[i].ale, tbl[i].oe, tbl[i].re, (i != 0));
        end

        // Reset asserted in the middle of the xWE low pulse.
        @(negedge CLK);
        REQ_OP = 3'd0; REQ_DATA = 8'h5A; REQ_LAST = 1'b0; REQ_VALID = 1'b1;
        @(posedge CLK);
        #1 REQ_VALID = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("mid.xwe_before", int'(xWE), 0);
        chk("mid.xce_before", int'(xCE), 0);
        #2 RST = 1'b1;
        #1;
        chk("mid.xwe_async", int'(xWE), 1);
        chk("mid.xce_async", int'(xCE), 1);
        chk("mid.cle_async", int'(CLE), 0);
        chk("mid.io_oe_async", int'(IO_OE), 0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("mid.ready_at_release", int'(REQ_READY), 0);
        rv_seen = 0;
        @(negedge CLK);
        chk("mid.ready_after", int'(REQ_READY), 1);
        for (int k = 0; k < 8; k++) begin
            if (RSP_VALID) rv_seen++;
            @(negedge CLK);
        end
        chk("mid.no_rsp", rv_seen, 0);
        m_ce = 1;
        m_rdata = 0;

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic [2:0] op;
            logic [7:0] d, io_v;
            logic       last;
            int         sel, rise;
            sel  = int'($urandom_range(0, 9));
            case (sel)
                0, 1:    op = 3'd0;
                2:       op = 3'd1;
                3, 4:    op = 3'd2;
                5, 6:    op = 3'd3;
                7, 8:    op = 3'd4;
                default: op = 3'($urandom_range(5, 7));
            endcase
            d    = 8'($urandom);
            io_v = 8'($urandom);
            last = ($urandom_range(0, 3) == 0);
            rise = int'($urandom_range(1, 40));
            run_op(op, d, last, io_v, rise);
            model(op, last, io_v, rise);
            check_op($sformatf("rnd%0d_op%0d", i, op), e_lat, e_err, m_rdata, e_ce,
                     e_we, e_cle, e_ale, e_oe, e_re, (i != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
